// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by the fetch queue and its consumers.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
   localparam int          INST_BYTES   = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_bus_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// A clear empties it without touching stored data.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [WIDTH-1:0]  mem [DEPTH];

   // Pointer and storage update; clear wins over push/pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: PC, credit-limited requests,
// and a FIFO of {pc, inst} pairs towards decode.
module if_fetch_queue
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       inst_req,
   output logic [ADDR_W-1:0]          inst_addr,
   input  logic [INST_W-1:0]          inst_rdata,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W+INST_W-1:0]   data_bus,
   output logic [$clog2(DEPTH):0]     fifo_level
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [CW-1:0]     room;
   logic              push;
   logic              pop;

   assign pop  = out_valid & out_ready;
   assign push = inflight & ~redirect_valid;

   // Entries committed once the in-flight response and pop land.
   assign room = count + CW'(inflight) - CW'(pop);

   assign inst_req  = reset & ~redirect_valid
                    & (room < CW'(DEPTH));
   assign inst_addr = pc;

   // PC advance, in-flight tracking and redirect restart.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= inst_req;
         if (redirect_valid) begin
            pc <= redirect_pc & ~ADDR_W'(3);
         end else if (inst_req) begin
            inflight_pc <= pc;
            pc          <= pc + ADDR_W'(INST_BYTES);
         end
      end
   end

   sync_fifo #(
      .WIDTH (ADDR_W + INST_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata ({inflight_pc, inst_rdata}),
      .rdata (data_bus),
      .count (count)
   );

   assign out_valid  = (count != '0);
   assign fifo_level = count;

   // Credit must keep a push away from a full, non-draining FIFO.
   full_push_a : assert property (
      @(posedge clk) disable iff (!reset)
      !(push && !pop && count == CW'(DEPTH))
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue.
// Directed scenarios on DEPTH=4, random stream on DEPTH=2/4/8.
module tb_if_fetch_queue;
   import fetch_pkg::*;

   localparam logic [31:0] RPC = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        out_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        ir  [3];
   logic [31:0] ia  [3];
   logic [31:0] rd  [3];
   logic        ov  [3];
   logic [63:0] db  [3];
   logic [2:0]  lvl0;
   logic [1:0]  lvl1;
   logic [3:0]  lvl2;
   logic [3:0]  lv  [3];
   int          dep [3];

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   if_fetch_queue #(.DEPTH(4)) u_dut (
      .clk(clk), .reset(reset),
      .inst_req(ir[0]), .inst_addr(ia[0]),
      .inst_rdata(rd[0]),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(ov[0]), .out_ready(out_ready),
      .data_bus(db[0]), .fifo_level(lvl0)
   );

   if_fetch_queue #(.DEPTH(2)) u_d2 (
      .clk(clk), .reset(reset),
      .inst_req(ir[1]), .inst_addr(ia[1]),
      .inst_rdata(rd[1]),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(ov[1]), .out_ready(out_ready),
      .data_bus(db[1]), .fifo_level(lvl1)
   );

   if_fetch_queue #(.DEPTH(8)) u_d8 (
      .clk(clk), .reset(reset),
      .inst_req(ir[2]), .inst_addr(ia[2]),
      .inst_rdata(rd[2]),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(ov[2]), .out_ready(out_ready),
      .data_bus(db[2]), .fifo_level(lvl2)
   );

   assign lv[0] = {1'b0, lvl0};
   assign lv[1] = {2'b0, lvl1};
   assign lv[2] = lvl2;

   // Memory: returns ~addr one cycle after the request.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         rd[k] <= ~ia[k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pc_of(logic [63:0] d);
      if_id_bus_t b;
      b = d;
      return b.pc;
   endfunction

   function automatic logic [31:0] inst_of(logic [63:0] d);
      if_id_bus_t b;
      b = d;
      return b.inst;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      out_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      tick();
      tick();
      n_tests++;
      if (ir[0] !== 1'b0 || ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_req_valid: req=%b valid=%b want 0 0",
                  ir[0], ov[0]);
      end
      n_tests++;
      if (lvl0 !== 3'd0 || db[0] !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_level_bus: lvl=%0d bus=%h want 0 0",
                  lvl0, db[0]);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (ir[0] !== 1'b1 || ia[0] !== RPC) begin
         n_fail++;
         $display("FAIL first_req: req=%b addr=%h want 1 %h",
                  ir[0], ia[0], RPC);
      end
   endtask

   task automatic test_stream();
      tick();
      n_tests++;
      if (ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_cycle1: valid=%b want 0", ov[0]);
      end
      tick();
      exp_pc = RPC;
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (ov[0] !== 1'b1 || pc_of(db[0]) !== exp_pc
             || inst_of(db[0]) !== ~exp_pc || lvl0 !== 3'd1) begin
            n_fail++;
            $display("FAIL stream_%0d: v=%b bus=%h lvl=%0d want pc %h",
                     i, ov[0], db[0], lvl0, exp_pc);
         end
         exp_pc += 4;
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_tests++;
      if (lvl0 !== 3'd4 || ir[0] !== 1'b0 || ov[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_full: lvl=%0d req=%b v=%b want 4 0 1",
                  lvl0, ir[0], ov[0]);
      end
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         n_tests++;
         if (ov[0] !== 1'b1 || pc_of(db[0]) !== exp_pc) begin
            n_fail++;
            $display("FAIL bp_drain_%0d: v=%b pc=%h want 1 %h",
                     i, ov[0], pc_of(db[0]), exp_pc);
         end
         exp_pc += 4;
         tick();
      end
   endtask

   task automatic test_redirect();
      n_tests++;
      if (lvl0 !== 3'd3) begin
         n_fail++;
         $display("FAIL redir_pre: lvl=%0d want 3", lvl0);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h1C00_0103;
      #1;
      n_tests++;
      if (ir[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_noreq: req=%b want 0", ir[0]);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if (ov[0] !== 1'b0 || lvl0 !== 3'd0 || ir[0] !== 1'b1
          || ia[0] !== 32'h1C00_0100) begin
         n_fail++;
         $display("FAIL redir_t1: v=%b lvl=%0d req=%b addr=%h",
                  ov[0], lvl0, ir[0], ia[0]);
      end
      tick();
      n_tests++;
      if (ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_t2: v=%b want 0", ov[0]);
      end
      tick();
      exp_pc = 32'h1C00_0100;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (ov[0] !== 1'b1 || pc_of(db[0]) !== exp_pc
             || inst_of(db[0]) !== ~exp_pc) begin
            n_fail++;
            $display("FAIL redir_entry_%0d: v=%b bus=%h want pc %h",
                     i, ov[0], db[0], exp_pc);
         end
         exp_pc += 4;
         tick();
      end
   endtask

   task automatic test_redirect_pop();
      n_tests++;
      if (ov[0] !== 1'b1 || lvl0 !== 3'd1) begin
         n_fail++;
         $display("FAIL rpop_pre: v=%b lvl=%0d want 1 1",
                  ov[0], lvl0);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h1C00_0200;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if (lvl0 !== 3'd0 || ov[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rpop_clear: lvl=%0d v=%b want 0 0",
                  lvl0, ov[0]);
      end
      tick();
      tick();
      n_tests++;
      if (ov[0] !== 1'b1 || pc_of(db[0]) !== 32'h1C00_0200) begin
         n_fail++;
         $display("FAIL rpop_entry: v=%b pc=%h want 1 1c000200",
                  ov[0], pc_of(db[0]));
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_tests++;
      if (ir[0] !== 1'b1 || ia[0] !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_addr0: req=%b addr=%h want 1 fffffffc",
                  ir[0], ia[0]);
      end
      tick();
      n_tests++;
      if (ia[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_addr1: addr=%h want 0", ia[0]);
      end
      tick();
      n_tests++;
      if (ov[0] !== 1'b1 || db[0] !== 64'hFFFF_FFFC_0000_0003) begin
         n_fail++;
         $display("FAIL wrap_entry0: v=%b bus=%h", ov[0], db[0]);
      end
      tick();
      n_tests++;
      if (ov[0] !== 1'b1 || db[0] !== 64'h0000_0000_FFFF_FFFF) begin
         n_fail++;
         $display("FAIL wrap_entry1: v=%b bus=%h", ov[0], db[0]);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h1234_5678;
      #1;
      n_tests++;
      if (ov[0] !== 1'b0 || lvl0 !== 3'd0 || ir[0] !== 1'b0
          || db[0] !== 64'd0) begin
         n_fail++;
         $display("FAIL rst_mid: v=%b lvl=%0d req=%b bus=%h",
                  ov[0], lvl0, ir[0], db[0]);
      end
      tick();
      redirect_valid = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      n_tests++;
      if (ir[0] !== 1'b1 || ia[0] !== RPC) begin
         n_fail++;
         $display("FAIL rst_mid_restart: req=%b addr=%h want 1 %h",
                  ir[0], ia[0], RPC);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp [3];
      int          pops [3];
      reset = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp[k] = RPC;
         pops[k] = 0;
      end
      for (int c = 0; c < 800; c++) begin
         out_ready = ($urandom_range(3) != 0);
         redirect_valid = ($urandom_range(19) == 0);
         redirect_pc = $urandom;
         #1;
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && out_ready) begin
               n_tests++;
               if (pc_of(db[k]) !== exp[k]
                   || inst_of(db[k]) !== ~exp[k]) begin
                  n_fail++;
                  $display("FAIL rand_d%0d_c%0d: bus=%h want pc %h",
                           dep[k], c, db[k], exp[k]);
               end
               exp[k] += 4;
               pops[k]++;
            end
            if (redirect_valid) exp[k] = redirect_pc & ~32'd3;
            n_tests++;
            if (lv[k] > 4'(dep[k]) || ov[k] !== (lv[k] != 0)) begin
               n_fail++;
               $display("FAIL rand_lvl_d%0d_c%0d: lvl=%0d v=%b",
                        dep[k], c, lv[k], ov[k]);
            end
         end
         tick();
      end
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (pops[k] < 200) begin
            n_fail++;
            $display("FAIL rand_progress_d%0d: pops=%0d want >=200",
                     dep[k], pops[k]);
         end
      end
   endtask

   initial begin
      dep[0] = 4;
      dep[1] = 2;
      dep[2] = 8;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
